// File: rtl/input_conditioner.sv
// Board input front end: 2-FF synchronisers for buttons and switches, per-button debounce
// with press/release pulses. Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses.
`timescale 1ns/1ps
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES      = 500_000,
    parameter int unsigned REPEAT_DELAY_CYCLES  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD_CYCLES = 5_000_000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [3:0]  btn_raw_in,
    input  logic [15:0] sw_raw_in,
    output logic [3:0]  btn_out,
    output logic [3:0]  btn_press_out,
    output logic [3:0]  btn_release_out,
    output logic [15:0] sw_out
);

    localparam int unsigned MaxAb     = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ?
                                        DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
    localparam int unsigned MaxCycles = (MaxAb > REPEAT_PERIOD_CYCLES) ?
                                        MaxAb : REPEAT_PERIOD_CYCLES;
    localparam int unsigned CNT_WIDTH = $clog2(MaxCycles) + 1;

    localparam logic [CNT_WIDTH-1:0] DbLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [3:0]  btn_meta_q, btn_sync_q;
    logic [15:0] sw_meta_q, sw_sync_q;
    logic [3:0]  stable_q, stable_d;
    logic [3:0]  press_q, press_d;
    logic [3:0]  release_q, release_d;
    logic [3:0]  accept;
    logic [3:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
        end else begin
            btn_meta_q <= btn_raw_in;
            btn_sync_q <= btn_meta_q;
            sw_meta_q  <= sw_raw_in;
            sw_sync_q  <= sw_meta_q;
        end
    end

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        cnt_d  = '0;
        accept = '0;
        for (int i = 0; i < 4; i++) begin
            if (btn_sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DbLast) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        stable_d  = stable_q ^ accept;
        release_d = accept & ~btn_sync_q;
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_WIDTH-1:0] RptLast   = CNT_WIDTH'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RptReload =
        CNT_WIDTH'(REPEAT_DELAY_CYCLES - REPEAT_PERIOD_CYCLES);

    logic [3:0][CNT_WIDTH-1:0] rcnt_q, rcnt_d;
    logic [3:0] rpt;

    // Repeats only while the accepted level is high and no edge is being accepted,
    // so a release-accept cycle never carries a press pulse.
    always_comb begin
        rcnt_d = '0;
        rpt    = '0;
        for (int i = 0; i < 4; i++) begin
            if (stable_q[i] && !accept[i]) begin
                if (rcnt_q[i] == RptLast) begin
                    rpt[i]    = 1'b1;
                    rcnt_d[i] = RptReload;
                end else begin
                    rcnt_d[i] = rcnt_q[i] + 1'b1;
                end
            end
        end
        press_d = (accept & btn_sync_q) | rpt;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end
`else
    always_comb begin
        press_d = accept & btn_sync_q;
    end
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q     <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_out         = stable_q;
    assign btn_press_out   = press_q;
    assign btn_release_out = release_q;
    assign sw_out          = sw_sync_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random button bursts, checked against
// a sliding-window reference model built from the per-edge input history.
`timescale 1ns/1ps
module tb_input_conditioner;

    localparam int DB   = 4;
    localparam int RD   = 6;
    localparam int RP   = 3;
    localparam int MAXE = 4096;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  btn_raw_in;
    logic [15:0] sw_raw_in;
    logic [3:0]  btn_out;
    logic [3:0]  btn_press_out;
    logic [3:0]  btn_release_out;
    logic [15:0] sw_out;

    input_conditioner #(
        .DEBOUNCE_CYCLES      (DB),
        .REPEAT_DELAY_CYCLES  (RD),
        .REPEAT_PERIOD_CYCLES (RP)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .btn_raw_in      (btn_raw_in),
        .sw_raw_in       (sw_raw_in),
        .btn_out         (btn_out),
        .btn_press_out   (btn_press_out),
        .btn_release_out (btn_release_out),
        .sw_out          (sw_out)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: raw inputs seen at each counted edge, and accepted levels.
    int          n;
    int          rbase;
    logic [3:0]  hb [MAXE];
    logic [15:0] hs [MAXE];
    logic [3:0]  m_st;
    int          lacc  [4];
    int          acc_e [4];
    logic [3:0]  e_press, e_rel;
    logic [15:0] e_sw;

    function automatic logic [3:0] sb(input int k);
        if (k <= rbase) return 4'b0;
        return hb[k];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s edge %0d: observed %h expected %h", tag, n, obs, exp);
        end
    endtask

    // A level is accepted when the synchronised sample disagreed with it on each of the
    // last DB edges, all of them after the previous acceptance (or reset).
    task automatic model_edge();
        logic [3:0] s;
        bit acc;
        n++;
        hb[n] = btn_raw_in;
        hs[n] = sw_raw_in;
        e_press = '0;
        e_rel   = '0;
        for (int b = 0; b < 4; b++) begin
            acc = (n - DB + 1 > lacc[b]);
            for (int e = n - DB + 1; e <= n; e++) begin
                s = sb(e - 2);
                if (s[b] == m_st[b]) acc = 1'b0;
            end
            if (acc) begin
                if (m_st[b] == 1'b0) begin
                    e_press[b] = 1'b1;
                    acc_e[b]   = n;
                end else begin
                    e_rel[b] = 1'b1;
                end
                lacc[b] = n;
            end else if (REP && m_st[b] && (n - acc_e[b] >= RD) &&
                         ((n - acc_e[b] - RD) % RP == 0)) begin
                e_press[b] = 1'b1;
            end
            if (acc) m_st[b] = ~m_st[b];
        end
        e_sw = (n - 1 <= rbase) ? 16'h0 : hs[n - 1];
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic [3:0] b, input logic [15:0] s);
        btn_raw_in = b;
        sw_raw_in  = s;
        @(posedge clk_in);
        model_edge();
        #1;
        check("btn_out", {12'h0, btn_out}, {12'h0, m_st});
        check("press", {12'h0, btn_press_out}, {12'h0, e_press});
        check("release", {12'h0, btn_release_out}, {12'h0, e_rel});
        check("sw_out", sw_out, e_sw);
        @(negedge clk_in);
    endtask

    task automatic hold(input logic [3:0] b, input logic [15:0] s, input int cycles);
        for (int i = 0; i < cycles; i++) step(b, s);
    endtask

    task automatic do_reset(input logic [3:0] b_assert, input logic [3:0] b_release);
        #2;
        btn_raw_in = b_assert;
        sw_raw_in  = 16'hFFFF;
        rst_in     = 1'b1;
        #1;
        check("rst_btn", {12'h0, btn_out}, 16'h0);
        check("rst_press", {12'h0, btn_press_out}, 16'h0);
        check("rst_release", {12'h0, btn_release_out}, 16'h0);
        check("rst_sw", sw_out, 16'h0);
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in     = 1'b0;
        btn_raw_in = b_release;
        rbase      = n;
        m_st       = '0;
        for (int b = 0; b < 4; b++) begin
            lacc[b]  = n;
            acc_e[b] = n;
        end
    endtask

    initial begin
        rst_in     = 1'b0;
        btn_raw_in = '0;
        sw_raw_in  = '0;
        n     = 0;
        rbase = 0;
        m_st  = '0;
        for (int b = 0; b < 4; b++) begin
            lacc[b]  = 0;
            acc_e[b] = 0;
        end
        @(negedge clk_in);

        // Async reset with all inputs high, then hold btnl.
        do_reset(4'hF, 4'b0001);
        hold(4'b0001, 16'h0000, 10);
        hold(4'b0000, 16'h0000, 8);

        // Bouncing btnu must never be accepted.
        for (int i = 0; i < 20; i++) step((i % 2 == 0) ? 4'b0100 : 4'b0000, 16'h0000);
        hold(4'b0000, 16'h0000, 8);

        // Clean press and release of btnr.
        hold(4'b0010, 16'h0000, 10);
        hold(4'b0000, 16'h0000, 10);

        // Switch path latency.
        hold(4'b0000, 16'hA5C3, 3);

        // Long hold of btnd (auto-repeat when enabled).
        hold(4'b1000, 16'hA5C3, 30);
        hold(4'b0000, 16'hA5C3, 10);

        // Reset while btnl is accepted and still held.
        hold(4'b0001, 16'h1234, 8);
        do_reset(4'b0001, 4'b0001);
        hold(4'b0001, 16'h1234, 8);
        hold(4'b0000, 16'h1234, 8);

        // Random bursts across all buttons and switches.
        for (int k = 0; k < 60; k++) begin
            logic [3:0] pat;
            int len;
            pat = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 9);
            for (int j = 0; j < len; j++) step(pat, 16'($urandom));
        end
        hold(4'b0000, 16'h0000, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
